lpt_tx_sequencer: RTL
=====================

# lpt_tx_sequencer

Hardware Centronics transmit engine for the LPT function. Host writes bytes into a small transmit FIFO. The sequencer drains the FIFO one byte at a time: it drives the data lines, waits for the printer to be ready, generates a timed STROBE pulse, then waits for the printer's acknowledge. It sits between the PCI I/O register decode and the LPT pins, and owns data[7:0] and STROBE whenever `enable` is high.

## Interface
Parameters:
- FIFO_DEPTH, 16: transmit FIFO entries; must be a power of 2.
- SETUP_CYCLES, 4: clocks that data is stable before STROBE falls.
- STROBE_CYCLES, 8: STROBE low width, in clocks.
- HOLD_CYCLES, 4: clocks that data is held after STROBE rises.
- TIMEOUT_CYCLES, 65535: maximum clocks in WAIT_READY or WAIT_ACK before error.

Ports:
- clk  in  1  system clock, shared with the PCI target.
- reset  in  1  synchronous, active-high.
- enable  in  1  engine enable (PXR-style control bit). When 0, no new byte is started.
- wr_en  in  1  FIFO push strobe from the register decode.
- wr_data  in  8  byte to push.
- clear_err  in  1  one-cycle pulse; clears the error and returns the engine to IDLE.
- BUSY  in  1  printer busy, active-high, asynchronous.
- ACK  in  1  printer acknowledge, active-low pulse, asynchronous.
- data  out  8  LPT data lines.
- STROBE  out  1  active-low strobe.
- fifo_full  out  1  FIFO full.
- fifo_empty  out  1  FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- active  out  1  engine is outside IDLE.
- timeout_err  out  1  sticky error flag.
- done_irq  out  1  one-cycle pulse when the FIFO drains empty after a successful byte.

## Operation
- BUSY and ACK each pass through a 2-flop synchronizer. Falling-edge detect on the synchronized ACK gives `ack_fall`.
- FIFO write behaviour:
  - A push while full is dropped; level is unchanged.
  - A push and a pop in the same cycle leave the level unchanged.
- States:
  - IDLE: if enable && !fifo_empty, pop one byte into `data_q` and go to WAIT_READY.
  - WAIT_READY: wait for synchronized BUSY = 0, then go to SETUP. If the timer reaches TIMEOUT_CYCLES first, go to ERROR.
  - SETUP: count SETUP_CYCLES, then go to STROBE.
  - STROBE: STROBE = 0; count STROBE_CYCLES, then go to HOLD.
  - HOLD: count HOLD_CYCLES, then go to WAIT_ACK.
  - WAIT_ACK: on `ack_fall`, go to IDLE. If the FIFO is now empty, pulse done_irq. On timeout, go to ERROR.
  - ERROR: timeout_err = 1. Stay until clear_err, then go to IDLE. The byte in error is discarded.
- One shared down-counter serves all timed states and is reloaded on every state entry. Width is wide enough for the largest parameter.
- An `ack_fall` that arrives during STROBE or HOLD is latched and satisfies WAIT_ACK on entry.
- If enable deasserts mid-byte, the current byte completes; no new byte is started.
- clear_err outside ERROR has no effect.
- `data` outputs `data_q` in all states; `data_q` holds the last byte sent.

## Timing
- Reset values:
  - state = IDLE
  - data = 8'hFF
  - STROBE = 1
  - FIFO empty, fifo_level = 0, fifo_empty = 1, fifo_full = 0
  - active = 0, timeout_err = 0, done_irq = 0
- Pop-to-pin latency: the cycle after the pop, `data` carries the new byte.
- Minimum byte time with the printer idle: 1 (IDLE) + 2 (BUSY synchronizer) + SETUP + STROBE + HOLD + ACK synchronizer + 1.
- STROBE low width is exactly STROBE_CYCLES clocks.
- Data is stable for at least SETUP_CYCLES before STROBE falls and at least HOLD_CYCLES after STROBE rises.
- A reset asserted in any state takes effect at the next clk edge. It forces STROBE high in that same cycle and flushes the FIFO.
- fifo_level, fifo_full and fifo_empty update in the cycle after wr_en or a pop.

## Structure
- Package `lpt_pkg` holds:
  - the state encoding constants: IDLE, WAIT_READY, SETUP, STROBE, HOLD, WAIT_ACK, ERROR;
  - the default timing constants;
  - the LPT register offset constants (PDR, PSR, PCR, PXR) shared with the register decode.
- Sub-module `lpt_tx_fifo`: synchronous FIFO with wrap-around pointers one bit wider than the address.
- Synchronizers and the FSM live in the top module.

## Test plan
- Push 8'hA5 with enable = 1 and BUSY = 0, then pulse ACK low 10 clocks after STROBE rises:
  - data = A5 from the cycle after the pop;
  - STROBE low for exactly 8 clocks, starting 4 clocks after SETUP entry;
  - done_irq pulses once; final state is IDLE.
- Push 17 bytes (0x00..0x10) into a 16-deep FIFO with enable = 0:
  - fifo_full = 1 and fifo_level = 16;
  - byte 0x10 is dropped;
  - after enabling with auto-ACK, exactly bytes 0x00..0x0F appear in order.
- Hold BUSY = 1 with TIMEOUT_CYCLES = 100:
  - ERROR is entered after 100 clocks in WAIT_READY; timeout_err = 1; STROBE stays high;
  - clear_err returns the engine to IDLE; the next queued byte is sent.
- Deliver the ACK pulse during the STROBE state:
  - the ACK is latched; WAIT_ACK exits in 1 clock; no timeout occurs.
- Assert reset during the STROBE state:
  - STROBE is high the next cycle; fifo_level = 0; data = FF; active = 0.
- Push and pop in the same cycle with the FIFO at level 5:
  - level stays 5; order is preserved.

Source files
------------

// File: rtl/lpt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpt_pkg
// Description : Shared definitions for the LPT transmit path. Holds the
//               sequencer state encoding, the default Centronics timing
//               constants, the LPT register offsets used by the register
//               decode, and a small helper for sizing the shared timer.
// Revision    : 1.0 - initial release
// ============================================================================
package lpt_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_SETUP      = 3'd2,
    S_STROBE     = 3'd3,
    S_HOLD       = 3'd4,
    S_WAIT_ACK   = 3'd5,
    S_ERROR      = 3'd6
  } lpt_state_e;

  // Default transmit timing, in clk cycles.
  localparam int LPT_FIFO_DEPTH     = 16;
  localparam int LPT_SETUP_CYCLES   = 4;
  localparam int LPT_STROBE_CYCLES  = 8;
  localparam int LPT_HOLD_CYCLES    = 4;
  localparam int LPT_TIMEOUT_CYCLES = 65535;

  // LPT register offsets shared with the register decode.
  localparam logic [1:0] LPT_PDR = 2'd0;  // data
  localparam logic [1:0] LPT_PSR = 2'd1;  // status
  localparam logic [1:0] LPT_PCR = 2'd2;  // control
  localparam logic [1:0] LPT_PXR = 2'd3;  // extended control

  function automatic int lpt_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpt_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lpt_tx_sequencer_if
// Description : Bundle of host-side FIFO/control signals and LPT pin signals
//               for the transmit sequencer.
//   master : host register decode + printer side (drives enable, wr_en,
//            wr_data, clear_err, BUSY, ACK; observes status and pins)
//   slave  : the sequencer (drives data, STROBE, FIFO status, active,
//            timeout_err, done_irq)
// Revision    : 1.0 - initial release
// ============================================================================
interface lpt_tx_sequencer_if
  import lpt_pkg::*;
#(
  parameter int FIFO_DEPTH = LPT_FIFO_DEPTH
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             enable;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clear_err;
  logic             BUSY;
  logic             ACK;
  logic [7:0]       data;
  logic             STROBE;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             active;
  logic             timeout_err;
  logic             done_irq;

  modport master (
    output enable, wr_en, wr_data, clear_err, BUSY, ACK,
    input  data, STROBE, fifo_full, fifo_empty, fifo_level, active, timeout_err, done_irq
  );

  modport slave (
    input  enable, wr_en, wr_data, clear_err, BUSY, ACK,
    output data, STROBE, fifo_full, fifo_empty, fifo_level, active, timeout_err, done_irq
  );
endinterface
`default_nettype wire

// File: rtl/lpt_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lpt_tx_fifo
// Description : Synchronous byte FIFO. Pointers carry one extra wrap bit so
//               full/empty/level fall out of a pointer subtraction.
//   clk, reset   : clock, synchronous active-high reset (flushes pointers)
//   push_i       : write request; ignored while full
//   pop_i        : read request; ignored while empty
//   wr_data_i    : byte to write
//   rd_data_o    : byte at the head (valid while not empty)
//   full_o, empty_o, level_o : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module lpt_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     push_i,
  input  wire logic                     pop_i,
  input  wire logic [7:0]               wr_data_i,
  output logic      [7:0]               rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok;
  logic        pop_ok;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign full_o    = (level_o == (AW+1)'(DEPTH));
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule
`default_nettype wire

// File: rtl/lpt_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lpt_tx_sequencer
// Description : Centronics transmit engine. Drains the transmit FIFO one
//               byte at a time: presents data, waits for !BUSY, issues a
//               timed active-low STROBE, then waits for the ACK falling edge.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : lpt_tx_sequencer_if.slave (host control/FIFO + LPT pins)
// Revision    : 1.0 - initial release
// ============================================================================
module lpt_tx_sequencer
  import lpt_pkg::*;
#(
  parameter int FIFO_DEPTH     = LPT_FIFO_DEPTH,
  parameter int SETUP_CYCLES   = LPT_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = LPT_STROBE_CYCLES,
  parameter int HOLD_CYCLES    = LPT_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = LPT_TIMEOUT_CYCLES
) (
  input wire logic             clk,
  input wire logic             reset,
  lpt_tx_sequencer_if.slave    bus
);
  localparam int TMR_MAX = lpt_max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  lpt_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       data_q, data_d;
  logic             strobe_q;
  logic             done_q, done_d;
  logic             ack_pend_q, ack_pend_d;
  logic             busy_s1_q, busy_s2_q;
  logic             ack_s1_q, ack_s2_q, ack_s3_q;
  logic             ack_fall;
  logic             timer_zero;
  logic             pop;
  logic [7:0]       fifo_rd_data;
  logic             fifo_empty;

  lpt_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (bus.wr_en),
    .pop_i     (pop),
    .wr_data_i (bus.wr_data),
    .rd_data_o (fifo_rd_data),
    .full_o    (bus.fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (bus.fifo_level)
  );

  // Each timed state starts with its full count minus one so that it
  // occupies exactly that many clocks.
  function automatic logic [TMR_W-1:0] reload(input lpt_state_e s);
    case (s)
      S_WAIT_READY, S_WAIT_ACK: reload = TMR_W'(TIMEOUT_CYCLES - 1);
      S_SETUP:                  reload = TMR_W'(SETUP_CYCLES - 1);
      S_STROBE:                 reload = TMR_W'(STROBE_CYCLES - 1);
      S_HOLD:                   reload = TMR_W'(HOLD_CYCLES - 1);
      default:                  reload = '0;
    endcase
  endfunction

  assign ack_fall   = ack_s3_q && !ack_s2_q;
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ack_pend_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && !fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_rd_data;
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (!busy_s2_q)      state_d = S_SETUP;
        else if (timer_zero) state_d = S_ERROR;
      end
      S_SETUP: begin
        if (timer_zero) state_d = S_STROBE;
      end
      S_STROBE: begin
        // An early acknowledge is remembered for WAIT_ACK.
        ack_pend_d = ack_pend_q || ack_fall;
        if (timer_zero) state_d = S_HOLD;
      end
      S_HOLD: begin
        ack_pend_d = ack_pend_q || ack_fall;
        if (timer_zero) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_fall || ack_pend_q) begin
          state_d = S_IDLE;
          done_d  = fifo_empty;
        end else if (timer_zero) begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        if (bus.clear_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)  timer_d = reload(state_d);
    else if (!timer_zero)    timer_d = timer_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      data_q     <= 8'hFF;
      strobe_q   <= 1'b1;
      done_q     <= 1'b0;
      ack_pend_q <= 1'b0;
      busy_s1_q  <= 1'b1;
      busy_s2_q  <= 1'b1;
      ack_s1_q   <= 1'b1;
      ack_s2_q   <= 1'b1;
      ack_s3_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      // Registered pin: low exactly while the FSM sits in STROBE.
      strobe_q   <= (state_d != S_STROBE);
      done_q     <= done_d;
      ack_pend_q <= ack_pend_d;
      busy_s1_q  <= bus.BUSY;
      busy_s2_q  <= busy_s1_q;
      ack_s1_q   <= bus.ACK;
      ack_s2_q   <= ack_s1_q;
      ack_s3_q   <= ack_s2_q;
    end
  end

  assign bus.data        = data_q;
  assign bus.STROBE      = strobe_q;
  assign bus.fifo_empty  = fifo_empty;
  assign bus.active      = (state_q != S_IDLE);
  assign bus.timeout_err = (state_q == S_ERROR);
  assign bus.done_irq    = done_q;
endmodule
`default_nettype wire
